id_ex_pipe_reg: RTL and testbench

//   Parametrised ID->EX pipeline register. It is a DEPTH-deep chain of stage slots and

---
 rtl/id_ex_pipe_reg_pkg.sv | 15 +
 rtl/id_ex_pipe_reg_slot.sv | 59 +++++
 rtl/id_ex_pipe_reg.sv | 148 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared constants and pipeline-control encoding for the ID/EX register and its
// EX/MEM and MEM/WB successors.
package id_ex_pipe_reg_pkg;

  localparam logic [31:0] PC_START  = 32'h0000_3000;
  localparam logic [5:0]  INSTR_NOP = 6'h00;

  typedef enum logic [1:0] {
    PIPE_ADV,
    PIPE_HOLD,
    PIPE_CLR,
    PIPE_FLUSH
  } pipe_ctrl_e;

endpackage

// File: rtl/id_ex_pipe_reg_slot.sv
// One pipeline slot: valid bit plus payload, with load / bubble / hold (neither) controls.
module pipe_slot
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         CODE_W   = 6,
  parameter logic [DATA_W-1:0]   PC_RESET = DATA_W'(PC_START),
  parameter logic [CODE_W-1:0]   NOP_CODE = CODE_W'(INSTR_NOP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] bubble_pc,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] pc_d,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [CODE_W-1:0] code_d,
  input  logic [DATA_W-1:0] rs_d,
  input  logic [DATA_W-1:0] rt_d,
  input  logic [DATA_W-1:0] imm_d,
  output logic              valid_q,
  output logic [DATA_W-1:0] pc_q,
  output logic [DATA_W-1:0] instr_q,
  output logic [CODE_W-1:0] code_q,
  output logic [DATA_W-1:0] rs_q,
  output logic [DATA_W-1:0] rt_q,
  output logic [DATA_W-1:0] imm_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      code_q  <= NOP_CODE;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
    end else if (bubble) begin
      valid_q <= 1'b0;
      pc_q    <= bubble_pc;
      instr_q <= '0;
      code_q  <= NOP_CODE;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
    end else if (load) begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      code_q  <= code_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: DEPTH chained slots with hold, clear, flush and
// saturating stall/bubble perf counters.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       CODE_W        = 6,
  parameter int unsigned       DEPTH         = 1,
  parameter logic [DATA_W-1:0] PC_RESET      = DATA_W'(PC_START),
  parameter logic [CODE_W-1:0] NOP_CODE      = CODE_W'(INSTR_NOP),
  parameter bit                CLEAR_KEEP_PC = 1'b1,
  parameter int unsigned       CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_in,
  input  logic              clear_in,
  input  logic              flush_all_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [CODE_W-1:0] code_in,
  input  logic [DATA_W-1:0] rs_data_in,
  input  logic [DATA_W-1:0] rt_data_in,
  input  logic [DATA_W-1:0] imm_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic [CODE_W-1:0] code_out,
  output logic [DATA_W-1:0] rs_data_out,
  output logic [DATA_W-1:0] rt_data_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned CW1 = CNT_W + 1;

  pipe_ctrl_e        ctrl;
  logic [DATA_W-1:0] bubble_pc;

  logic              valid_q [DEPTH];
  logic [DATA_W-1:0] pc_q    [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [CODE_W-1:0] code_q  [DEPTH];
  logic [DATA_W-1:0] rs_q    [DEPTH];
  logic [DATA_W-1:0] rt_q    [DEPTH];
  logic [DATA_W-1:0] imm_q   [DEPTH];

  // Reset is handled inside each slot; this decode covers the remaining priority chain.
  always_comb begin
    ctrl = PIPE_ADV;
    if (flush_all_in)  ctrl = PIPE_FLUSH;
    else if (hold_in)  ctrl = PIPE_HOLD;
    else if (clear_in) ctrl = PIPE_CLR;
  end

  assign bubble_pc = CLEAR_KEEP_PC ? pc_in : PC_RESET;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              v_d;
    logic [DATA_W-1:0] pc_d, instr_d, rs_d, rt_d, imm_d;
    logic [CODE_W-1:0] code_d;
    logic              load, bubble;

    if (k == 0) begin : g_head
      assign v_d     = valid_in;
      assign pc_d    = pc_in;
      assign instr_d = instr_in;
      assign code_d  = code_in;
      assign rs_d    = rs_data_in;
      assign rt_d    = rt_data_in;
      assign imm_d   = imm_in;
      assign load    = (ctrl == PIPE_ADV);
      assign bubble  = (ctrl == PIPE_FLUSH) || (ctrl == PIPE_CLR);
    end else begin : g_tail
      assign v_d     = valid_q[k-1];
      assign pc_d    = pc_q[k-1];
      assign instr_d = instr_q[k-1];
      assign code_d  = code_q[k-1];
      assign rs_d    = rs_q[k-1];
      assign rt_d    = rt_q[k-1];
      assign imm_d   = imm_q[k-1];
      assign load    = (ctrl == PIPE_ADV) || (ctrl == PIPE_CLR);
      assign bubble  = (ctrl == PIPE_FLUSH);
    end

    pipe_slot #(
      .DATA_W   (DATA_W),
      .CODE_W   (CODE_W),
      .PC_RESET (PC_RESET),
      .NOP_CODE (NOP_CODE)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .bubble    (bubble),
      .bubble_pc (bubble_pc),
      .valid_d   (v_d),
      .pc_d      (pc_d),
      .instr_d   (instr_d),
      .code_d    (code_d),
      .rs_d      (rs_d),
      .rt_d      (rt_d),
      .imm_d     (imm_d),
      .valid_q   (valid_q[k]),
      .pc_q      (pc_q[k]),
      .instr_q   (instr_q[k]),
      .code_q    (code_q[k]),
      .rs_q      (rs_q[k]),
      .rt_q      (rt_q[k]),
      .imm_q     (imm_q[k])
    );
  end

  assign valid_out   = valid_q[DEPTH-1];
  assign pc_out      = pc_q[DEPTH-1];
  assign instr_out   = instr_q[DEPTH-1];
  assign code_out    = code_q[DEPTH-1];
  assign rs_data_out = rs_q[DEPTH-1];
  assign rt_data_out = rt_q[DEPTH-1];
  assign imm_out     = imm_q[DEPTH-1];

  logic [CW1-1:0] stall_sum, bubble_sum, bubble_inc;

  // One guard bit catches overflow so the counters clamp instead of wrapping.
  always_comb begin
    bubble_inc = '0;
    case (ctrl)
      PIPE_CLR:   bubble_inc = CW1'(1);
      PIPE_FLUSH: bubble_inc = CW1'(DEPTH);
      default:    bubble_inc = '0;
    endcase
    stall_sum  = {1'b0, stall_cnt} + CW1'(ctrl == PIPE_HOLD);
    bubble_sum = {1'b0, bubble_cnt} + bubble_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cnt  <= stall_sum[CNT_W]  ? '1 : stall_sum[CNT_W-1:0];
      bubble_cnt <= bubble_sum[CNT_W] ? '1 : bubble_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: two configurations share one stimulus stream and are
// checked against a queue-based transaction model through per-cycle scoreboards.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  code;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
  } slot_t;

  typedef slot_t slot_q_t[$];

  typedef struct {
    slot_t       s;
    int unsigned st;
    int unsigned bu;
  } exp_t;

  localparam int unsigned DEPTH_A = 3, CNT_A = 6;
  localparam int unsigned DEPTH_B = 1, CNT_B = 4;
  localparam logic [5:0]  NOP_A = 6'h00, NOP_B = 6'h15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, hold_in = 1'b0, clear_in = 1'b0, flush_all_in = 1'b0, valid_in = 1'b0;
  logic [31:0] pc_in = '0, instr_in = '0, rs_data_in = '0, rt_data_in = '0, imm_in = '0;
  logic [5:0]  code_in = '0;

  logic              valid_out_a, valid_out_b;
  logic [31:0]       pc_out_a, instr_out_a, rs_data_out_a, rt_data_out_a, imm_out_a;
  logic [31:0]       pc_out_b, instr_out_b, rs_data_out_b, rt_data_out_b, imm_out_b;
  logic [5:0]        code_out_a, code_out_b;
  logic [CNT_A-1:0]  stall_cnt_a, bubble_cnt_a;
  logic [CNT_B-1:0]  stall_cnt_b, bubble_cnt_b;

  id_ex_pipe_reg #(
    .DATA_W(32), .CODE_W(6), .DEPTH(DEPTH_A), .PC_RESET(32'h3000),
    .NOP_CODE(NOP_A), .CLEAR_KEEP_PC(1'b1), .CNT_W(CNT_A)
  ) dut_a (
    .clk(clk), .reset(reset), .hold_in(hold_in), .clear_in(clear_in),
    .flush_all_in(flush_all_in), .valid_in(valid_in), .pc_in(pc_in),
    .instr_in(instr_in), .code_in(code_in), .rs_data_in(rs_data_in),
    .rt_data_in(rt_data_in), .imm_in(imm_in),
    .valid_out(valid_out_a), .pc_out(pc_out_a), .instr_out(instr_out_a),
    .code_out(code_out_a), .rs_data_out(rs_data_out_a), .rt_data_out(rt_data_out_a),
    .imm_out(imm_out_a), .stall_cnt(stall_cnt_a), .bubble_cnt(bubble_cnt_a)
  );

  id_ex_pipe_reg #(
    .DATA_W(32), .CODE_W(6), .DEPTH(DEPTH_B), .PC_RESET(32'h3000),
    .NOP_CODE(NOP_B), .CLEAR_KEEP_PC(1'b0), .CNT_W(CNT_B)
  ) dut_b (
    .clk(clk), .reset(reset), .hold_in(hold_in), .clear_in(clear_in),
    .flush_all_in(flush_all_in), .valid_in(valid_in), .pc_in(pc_in),
    .instr_in(instr_in), .code_in(code_in), .rs_data_in(rs_data_in),
    .rt_data_in(rt_data_in), .imm_in(imm_in),
    .valid_out(valid_out_b), .pc_out(pc_out_b), .instr_out(instr_out_b),
    .code_out(code_out_b), .rs_data_out(rs_data_out_b), .rt_data_out(rt_data_out_b),
    .imm_out(imm_out_b), .stall_cnt(stall_cnt_b), .bubble_cnt(bubble_cnt_b)
  );

  int unsigned checks = 0, errors = 0;
  exp_t        exp_a[$], exp_b[$];
  slot_q_t     qa, qb;
  int unsigned sa = 0, ba = 0, sb = 0, bb = 0;

  // Transaction-level model: the pipe is a queue of DEPTH instructions, oldest at the back.
  function automatic slot_q_t model_step(slot_q_t q, int unsigned depth, bit keep,
                                         logic [5:0] nop, bit r, bit f, bit h, bit c,
                                         slot_t in);
    slot_q_t n;
    slot_t   rst_s, bub;
    rst_s = '{valid: 1'b0, pc: 32'h3000, instr: '0, code: nop, rs: '0, rt: '0, imm: '0};
    bub   = '{valid: 1'b0, pc: keep ? in.pc : 32'h3000, instr: '0, code: nop,
              rs: '0, rt: '0, imm: '0};
    if (r) begin
      repeat (depth) n.push_back(rst_s);
    end else if (f) begin
      repeat (depth) n.push_back(bub);
    end else if (h) begin
      n = q;
    end else begin
      n = q;
      n.push_front(c ? bub : in);
      void'(n.pop_back());
    end
    return n;
  endfunction

  function automatic int unsigned sat(int unsigned v, int unsigned inc, int unsigned max);
    return (v + inc > max) ? max : v + inc;
  endfunction

  function automatic slot_t mk(bit v, logic [31:0] pc);
    slot_t s;
    s.valid = v;
    s.pc    = pc;
    s.instr = $urandom;
    s.code  = 6'($urandom_range(0, 63));
    s.rs    = $urandom;
    s.rt    = $urandom;
    s.imm   = $urandom;
    return s;
  endfunction

  task automatic cyc(input bit r, input bit f, input bit h, input bit c, input slot_t in);
    @(negedge clk);
    reset = r; flush_all_in = f; hold_in = h; clear_in = c;
    valid_in = in.valid; pc_in = in.pc; instr_in = in.instr; code_in = in.code;
    rs_data_in = in.rs; rt_data_in = in.rt; imm_in = in.imm;
    qa = model_step(qa, DEPTH_A, 1'b1, NOP_A, r, f, h, c, in);
    qb = model_step(qb, DEPTH_B, 1'b0, NOP_B, r, f, h, c, in);
    if (r) begin
      sa = 0; ba = 0; sb = 0; bb = 0;
    end else if (f) begin
      ba = sat(ba, DEPTH_A, (1 << CNT_A) - 1);
      bb = sat(bb, DEPTH_B, (1 << CNT_B) - 1);
    end else if (h) begin
      sa = sat(sa, 1, (1 << CNT_A) - 1);
      sb = sat(sb, 1, (1 << CNT_B) - 1);
    end else if (c) begin
      ba = sat(ba, 1, (1 << CNT_A) - 1);
      bb = sat(bb, 1, (1 << CNT_B) - 1);
    end
    exp_a.push_back('{s: qa[$], st: sa, bu: ba});
    exp_b.push_back('{s: qb[$], st: sb, bu: bb});
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t  ea, eb;
    slot_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a.size() > 0) begin
        ea  = exp_a.pop_front();
        got = {valid_out_a, pc_out_a, instr_out_a, code_out_a, rs_data_out_a,
               rt_data_out_a, imm_out_a};
        checks++;
        if (got !== ea.s || stall_cnt_a !== CNT_A'(ea.st) || bubble_cnt_a !== CNT_A'(ea.bu)) begin
          errors++;
          $display("FAIL dut_a t=%0t got v=%b pc=%h ins=%h code=%h rs=%h rt=%h imm=%h st=%0d bu=%0d exp v=%b pc=%h ins=%h code=%h rs=%h rt=%h imm=%h st=%0d bu=%0d",
                   $time, got.valid, got.pc, got.instr, got.code, got.rs, got.rt, got.imm,
                   stall_cnt_a, bubble_cnt_a, ea.s.valid, ea.s.pc, ea.s.instr, ea.s.code,
                   ea.s.rs, ea.s.rt, ea.s.imm, ea.st, ea.bu);
        end
      end
      if (exp_b.size() > 0) begin
        eb  = exp_b.pop_front();
        got = {valid_out_b, pc_out_b, instr_out_b, code_out_b, rs_data_out_b,
               rt_data_out_b, imm_out_b};
        checks++;
        if (got !== eb.s || stall_cnt_b !== CNT_B'(eb.st) || bubble_cnt_b !== CNT_B'(eb.bu)) begin
          errors++;
          $display("FAIL dut_b t=%0t got v=%b pc=%h ins=%h code=%h rs=%h rt=%h imm=%h st=%0d bu=%0d exp v=%b pc=%h ins=%h code=%h rs=%h rt=%h imm=%h st=%0d bu=%0d",
                   $time, got.valid, got.pc, got.instr, got.code, got.rs, got.rt, got.imm,
                   stall_cnt_b, bubble_cnt_b, eb.s.valid, eb.s.pc, eb.s.instr, eb.s.code,
                   eb.s.rs, eb.s.rt, eb.s.imm, eb.st, eb.bu);
        end
      end
    end
  end

  initial begin
    bit r, f, h, c;
    // Reset, then a short in-order stream.
    cyc(1, 0, 0, 0, mk(1, 32'hDEAD_0000));
    cyc(1, 0, 0, 0, mk(0, 32'h0));
    cyc(0, 0, 0, 0, mk(1, 32'h3000));
    cyc(0, 0, 0, 0, mk(1, 32'h3004));
    cyc(0, 0, 0, 0, mk(1, 32'h3008));
    cyc(0, 0, 0, 0, mk(1, 32'h300C));
    // Two-cycle stall with the upstream repeating, then resume.
    cyc(0, 0, 1, 0, mk(1, 32'h3010));
    cyc(0, 0, 1, 0, mk(1, 32'h3010));
    cyc(0, 0, 0, 0, mk(1, 32'h3010));
    cyc(0, 0, 0, 0, mk(1, 32'h3014));
    // Hold beats clear; then a lone clear.
    cyc(0, 0, 1, 1, mk(1, 32'h3018));
    cyc(0, 0, 0, 1, mk(1, 32'h3010));
    repeat (3) cyc(0, 0, 0, 0, mk(1, 32'h3020));
    // Flush while holding, then reset while holding and flushing.
    cyc(0, 1, 1, 0, mk(1, 32'h3030));
    repeat (2) cyc(0, 0, 0, 0, mk(1, 32'h3034));
    cyc(1, 1, 1, 1, mk(1, 32'h3040));
    cyc(0, 0, 0, 0, mk(1, 32'h3044));
    // Long stall run saturates the narrow counters.
    repeat (70) cyc(0, 0, 1, 0, mk(1, 32'h3048));
    repeat (4) cyc(0, 0, 0, 0, mk(1, 32'h304C));
    cyc(1, 0, 0, 0, mk(0, 32'h0));
    // Randomised mix of all controls.
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 99) < 5);
      h = ($urandom_range(0, 99) < 15);
      c = ($urandom_range(0, 99) < 12);
      cyc(r, f, h, c, mk(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF), 2'b00}));
    end
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
